// File: rtl/qspi_ram_pkg.sv
// -----------------------------------------------------------------------------
// qspi_ram_pkg
//
// Purpose: shared definitions for the single-byte QSPI PSRAM controller.
//   - state_t              : controller FSM states
//   - CMD_*_DEFAULT        : default SPI-mode opcodes (quad read / quad write)
//   - DUMMY_SCLK_DEFAULT   : default wait SCLKs between address and read data
//   - CMD_BITS, ADDR_NIBBLES, DATA_NIBBLES, DESEL_CYCLES : phase lengths
//   - top_align_byte()     : places a byte in the top of the 24-bit shifter
// -----------------------------------------------------------------------------
package qspi_ram_pkg;

    typedef enum logic [2:0] {
        IDLE,
        CMD,
        ADDR,
        DUMMY,
        DATA,
        DESEL
    } state_t;

    localparam logic [7:0] CMD_READ_DEFAULT   = 8'hEB;
    localparam logic [7:0] CMD_WRITE_DEFAULT  = 8'h38;
    localparam int         DUMMY_SCLK_DEFAULT = 6;

    localparam int CMD_BITS     = 8;
    localparam int ADDR_NIBBLES = 6;
    localparam int DATA_NIBBLES = 2;
    localparam int DESEL_CYCLES = 2;

    // The shifter always presents its most significant bits on the pins, so
    // byte-wide payloads (opcode, write data) are loaded into bits [23:16].
    function automatic logic [23:0] top_align_byte(input logic [7:0] b);
        return {b, 16'h0000};
    endfunction

endpackage

// File: rtl/qspi_nibble_shifter.sv
// -----------------------------------------------------------------------------
// qspi_nibble_shifter
//
// Purpose: 24-bit load/shift register feeding the QSPI output pins. The pins
// always see the top nibble; the command phase uses bit [23] only.
//
// Ports:
//   clk, rst_n  : clock, asynchronous active-low reset
//   load        : load load_val (highest priority)
//   load_val    : 24-bit value to load
//   shift4      : shift left by one nibble
//   shift1      : shift left by one bit
//   head        : current top nibble (bits [23:20])
// -----------------------------------------------------------------------------
module qspi_nibble_shifter (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [23:0] load_val,
    input  logic        shift4,
    input  logic        shift1,
    output logic [3:0]  head
);

    logic [23:0] sh_q;
    logic [23:0] sh_d;

    always_comb begin
        sh_d = sh_q;
        if (load) begin
            sh_d = load_val;
        end else if (shift4) begin
            sh_d = {sh_q[19:0], 4'h0};
        end else if (shift1) begin
            sh_d = {sh_q[22:0], 1'b0};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q <= '0;
        end else begin
            sh_q <= sh_d;
        end
    end

    assign head = sh_q[23:20];

endmodule

// File: rtl/qspi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// qspi_ram_ctrl
//
// Purpose: single-byte QSPI PSRAM controller. Accepts one read or write
// request at a time from the core memory port and runs a complete SPI-mode
// transaction on the RAM PMOD: opcode serially on io0, then 24-bit address
// and data four bits per SCLK. SCLK runs at clk/2 (phase L then phase H).
//
// Ports:
//   clk, rst_n             : system clock, asynchronous active-low reset
//   req_valid / req_ready  : request handshake (ready only while idle)
//   req_rnw                : 1 = read, 0 = write
//   req_addr, req_bank     : byte address, PMOD bank select
//   req_wdata              : write byte
//   rdata, rdata_valid     : read byte and its one-cycle valid pulse
//   ram_csn, ram_clk       : chip select (active low), SCLK
//   ram_bank               : bank select latched at accept
//   ram_io_o / ram_io_oe   : io3..io0 output values and enables
//   ram_io_i               : io3..io0 input values
// -----------------------------------------------------------------------------
module qspi_ram_ctrl
    import qspi_ram_pkg::*;
#(
    parameter logic [7:0] CMD_READ   = CMD_READ_DEFAULT,
    parameter logic [7:0] CMD_WRITE  = CMD_WRITE_DEFAULT,
    parameter int         DUMMY_SCLK = DUMMY_SCLK_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_rnw,
    input  logic [23:0] req_addr,
    input  logic [1:0]  req_bank,
    input  logic [7:0]  req_wdata,
    output logic [7:0]  rdata,
    output logic        rdata_valid,
    output logic        ram_csn,
    output logic        ram_clk,
    output logic [1:0]  ram_bank,
    output logic [3:0]  ram_io_o,
    output logic [3:0]  ram_io_oe,
    input  logic [3:0]  ram_io_i
);

    localparam int DUMMY_W = (DUMMY_SCLK > 1) ? $clog2(DUMMY_SCLK) : 1;

    localparam logic [2:0]         CMD_LAST   = 3'(CMD_BITS - 1);
    localparam logic [2:0]         ADDR_LAST  = 3'(ADDR_NIBBLES - 1);
    localparam logic [2:0]         DATA_LAST  = 3'(DATA_NIBBLES - 1);
    localparam logic [DUMMY_W-1:0] DUMMY_LAST = DUMMY_W'((DUMMY_SCLK > 0) ? (DUMMY_SCLK - 1) : 0);
    localparam logic [1:0]         DESEL_LAST = 2'(DESEL_CYCLES - 1);

    state_t               state_q,     state_d;
    logic                 phase_q,     phase_d;
    logic [2:0]           bit_cnt_q,   bit_cnt_d;
    logic [2:0]           nib_cnt_q,   nib_cnt_d;
    logic [DUMMY_W-1:0]   dummy_cnt_q, dummy_cnt_d;
    logic [1:0]           desel_cnt_q, desel_cnt_d;

    logic                 rnw_q,   rnw_d;
    logic [23:0]          addr_q,  addr_d;
    logic [7:0]           wdata_q, wdata_d;
    logic [1:0]           bank_q,  bank_d;

    logic [3:0]           rd_hi_q,       rd_hi_d;
    logic [7:0]           rdata_q,       rdata_d;
    logic                 rdata_valid_q, rdata_valid_d;

    logic                 sh_load;
    logic [23:0]          sh_load_val;
    logic                 sh_shift1;
    logic                 sh_shift4;
    logic [3:0]           sh_head;

    qspi_nibble_shifter u_shifter (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (sh_load),
        .load_val (sh_load_val),
        .shift4   (sh_shift4),
        .shift1   (sh_shift1),
        .head     (sh_head)
    );

    // Next-state logic. In every transfer state phase toggles each clk; all
    // per-SCLK work (state advance, shifting, read sampling) happens on the
    // clk edge that ends phase H, so the pins only move on entry to phase L.
    always_comb begin
        state_d       = state_q;
        phase_d       = phase_q;
        bit_cnt_d     = bit_cnt_q;
        nib_cnt_d     = nib_cnt_q;
        dummy_cnt_d   = dummy_cnt_q;
        desel_cnt_d   = desel_cnt_q;
        rnw_d         = rnw_q;
        addr_d        = addr_q;
        wdata_d       = wdata_q;
        bank_d        = bank_q;
        rd_hi_d       = rd_hi_q;
        rdata_d       = rdata_q;
        rdata_valid_d = 1'b0;
        sh_load       = 1'b0;
        sh_load_val   = '0;
        sh_shift1     = 1'b0;
        sh_shift4     = 1'b0;

        case (state_q)
            IDLE: begin
                phase_d = 1'b0;
                if (req_valid) begin
                    rnw_d       = req_rnw;
                    addr_d      = req_addr;
                    wdata_d     = req_wdata;
                    bank_d      = req_bank;
                    state_d     = CMD;
                    bit_cnt_d   = '0;
                    sh_load     = 1'b1;
                    sh_load_val = top_align_byte(req_rnw ? CMD_READ : CMD_WRITE);
                end
            end

            CMD: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (bit_cnt_q == CMD_LAST) begin
                        state_d     = ADDR;
                        nib_cnt_d   = '0;
                        sh_load     = 1'b1;
                        sh_load_val = addr_q;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        sh_shift1 = 1'b1;
                    end
                end
            end

            ADDR: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (nib_cnt_q == ADDR_LAST) begin
                        if (rnw_q && (DUMMY_SCLK != 0)) begin
                            state_d     = DUMMY;
                            dummy_cnt_d = '0;
                        end else begin
                            state_d     = DATA;
                            nib_cnt_d   = '0;
                            sh_load     = 1'b1;
                            sh_load_val = top_align_byte(wdata_q);
                        end
                    end else begin
                        nib_cnt_d = nib_cnt_q + 3'd1;
                        sh_shift4 = 1'b1;
                    end
                end
            end

            DUMMY: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (dummy_cnt_q == DUMMY_LAST) begin
                        state_d   = DATA;
                        nib_cnt_d = '0;
                    end else begin
                        dummy_cnt_d = dummy_cnt_q + 1'b1;
                    end
                end
            end

            // Reads collect the high nibble first and publish the whole byte
            // together with the valid pulse, so an aborted read never
            // disturbs rdata.
            DATA: begin
                phase_d = ~phase_q;
                if (phase_q) begin
                    if (nib_cnt_q == DATA_LAST) begin
                        state_d     = DESEL;
                        desel_cnt_d = '0;
                        if (rnw_q) begin
                            rdata_d       = {rd_hi_q, ram_io_i};
                            rdata_valid_d = 1'b1;
                        end
                    end else begin
                        nib_cnt_d = nib_cnt_q + 3'd1;
                        sh_shift4 = 1'b1;
                        if (rnw_q) begin
                            rd_hi_d = ram_io_i;
                        end
                    end
                end
            end

            DESEL: begin
                phase_d = 1'b0;
                if (desel_cnt_q == DESEL_LAST) begin
                    state_d = IDLE;
                end else begin
                    desel_cnt_d = desel_cnt_q + 2'd1;
                end
            end

            default: begin
                state_d = IDLE;
                phase_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            phase_q       <= 1'b0;
            bit_cnt_q     <= '0;
            nib_cnt_q     <= '0;
            dummy_cnt_q   <= '0;
            desel_cnt_q   <= '0;
            rnw_q         <= 1'b0;
            addr_q        <= '0;
            wdata_q       <= '0;
            bank_q        <= '0;
            rd_hi_q       <= '0;
            rdata_q       <= '0;
            rdata_valid_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            phase_q       <= phase_d;
            bit_cnt_q     <= bit_cnt_d;
            nib_cnt_q     <= nib_cnt_d;
            dummy_cnt_q   <= dummy_cnt_d;
            desel_cnt_q   <= desel_cnt_d;
            rnw_q         <= rnw_d;
            addr_q        <= addr_d;
            wdata_q       <= wdata_d;
            bank_q        <= bank_d;
            rd_hi_q       <= rd_hi_d;
            rdata_q       <= rdata_d;
            rdata_valid_q <= rdata_valid_d;
        end
    end

    // Pin decode is a pure function of registered state, so an asynchronous
    // reset returns every pin to its idle level immediately. phase_q is only
    // ever 1 inside a transfer state, so it can drive SCLK directly.
    always_comb begin
        req_ready = (state_q == IDLE);
        ram_csn   = (state_q == IDLE) || (state_q == DESEL);
        ram_clk   = phase_q;
        ram_io_o  = 4'h0;
        ram_io_oe = 4'h0;
        case (state_q)
            CMD: begin
                ram_io_o  = {3'b000, sh_head[3]};
                ram_io_oe = 4'b0001;
            end
            ADDR: begin
                ram_io_o  = sh_head;
                ram_io_oe = 4'b1111;
            end
            DATA: begin
                if (!rnw_q) begin
                    ram_io_o  = sh_head;
                    ram_io_oe = 4'b1111;
                end
            end
            default: begin
                ram_io_o  = 4'h0;
                ram_io_oe = 4'h0;
            end
        endcase
    end

    assign rdata       = rdata_q;
    assign rdata_valid = rdata_valid_q;
    assign ram_bank    = bank_q;

endmodule

// File: tb/tb_qspi_ram_ctrl.sv
// -----------------------------------------------------------------------------
// tb_qspi_ram_ctrl
//
// Directed bench for qspi_ram_ctrl. Cycle k of a transaction is the k-th clk
// cycle after the accept edge; pins are captured on the falling clk edge in
// the middle of that cycle. A small PSRAM model decodes the opcode/address
// from the pins and answers 0xEB reads with m_rdata.
// -----------------------------------------------------------------------------
module tb_qspi_ram_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_rnw = 1'b0;
    logic [23:0] req_addr = '0;
    logic [1:0]  req_bank = '0;
    logic [7:0]  req_wdata = '0;
    logic        req_ready;
    logic [7:0]  rdata;
    logic        rdata_valid;
    logic        ram_csn;
    logic        ram_clk;
    logic [1:0]  ram_bank;
    logic [3:0]  ram_io_o;
    logic [3:0]  ram_io_oe;
    logic [3:0]  ram_io_i = 4'h0;

    int total = 0;
    int bad = 0;

    logic       cap_csn   [0:127];
    logic       cap_clk   [0:127];
    logic       cap_ready [0:127];
    logic       cap_rv    [0:127];
    logic [1:0] cap_bank  [0:127];
    logic [3:0] cap_o     [0:127];
    logic [3:0] cap_oe    [0:127];
    logic [7:0] cap_rdata [0:127];

    always #5 clk = ~clk;

    qspi_ram_ctrl dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_rnw     (req_rnw),
        .req_addr    (req_addr),
        .req_bank    (req_bank),
        .req_wdata   (req_wdata),
        .rdata       (rdata),
        .rdata_valid (rdata_valid),
        .ram_csn     (ram_csn),
        .ram_clk     (ram_clk),
        .ram_bank    (ram_bank),
        .ram_io_o    (ram_io_o),
        .ram_io_oe   (ram_io_oe),
        .ram_io_i    (ram_io_i)
    );

    // PSRAM model: counts SCLK rising edges while selected, shifts in the
    // opcode (8 edges on io0) and address (6 nibble edges).
    int          m_edges = 0;
    logic [7:0]  m_cmd = 8'h00;
    logic [23:0] m_addr = 24'h0;
    logic [7:0]  m_rdata = 8'h3C;

    always @(posedge ram_clk or posedge ram_csn) begin
        if (ram_csn) begin
            m_edges = 0;
        end else begin
            if (m_edges < 8) m_cmd = {m_cmd[6:0], ram_io_o[0]};
            else if (m_edges < 14) m_addr = {m_addr[19:0], ram_io_o};
            m_edges = m_edges + 1;
        end
    end

    // Read data is launched shortly after the falling SCLK edge that starts
    // each of the two data SCLKs (after 20 and 21 rising edges).
    always @(negedge ram_clk or posedge ram_csn) begin
        if (ram_csn) begin
            ram_io_i = 4'h0;
        end else begin
            #1;
            if (m_cmd == 8'hEB && m_edges == 20) ram_io_i = m_rdata[7:4];
            else if (m_cmd == 8'hEB && m_edges == 21) ram_io_i = m_rdata[3:0];
            else ram_io_i = 4'h0;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: time limit reached, got no finish expected finish");
        $fatal(1, "[TB] watchdog");
    end

    function automatic logic [7:0] cmd_byte(input int base);
        logic [7:0] b = 8'h00;
        for (int i = 0; i < 8; i++) b = {b[6:0], cap_o[base + 2 * i][0]};
        return b;
    endfunction

    function automatic logic [23:0] nibbles(input int base, input int n);
        logic [23:0] v = 24'h0;
        for (int i = 0; i < n; i++) v = {v[19:0], cap_o[base + 2 * i]};
        return v;
    endfunction

    function automatic int count_csn_low(input int first, input int last);
        int c = 0;
        for (int k = first; k <= last; k++) if (cap_csn[k] === 1'b0) c++;
        return c;
    endfunction

    function automatic int count_rv(input int first, input int last);
        int c = 0;
        for (int k = first; k <= last; k++) if (cap_rv[k] !== 1'b0) c++;
        return c;
    endfunction

    task automatic start_req(input logic rnw, input logic [23:0] addr, input logic [1:0] bank,
                             input logic [7:0] wdata, input bit hold);
        int budget = 0;
        @(negedge clk);
        while (req_ready !== 1'b1 && budget < 200) begin
            @(negedge clk);
            budget++;
        end
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("[TB] FAIL start_ready: req_ready=%b expected 1 within 200 cycles", req_ready);
        end
        req_rnw   = rnw;
        req_addr  = addr;
        req_bank  = bank;
        req_wdata = wdata;
        req_valid = 1'b1;
        @(posedge clk);
        #1;
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic capture(input int first, input int last, input bit scramble);
        for (int k = first; k <= last; k++) begin
            @(negedge clk);
            cap_csn[k]   = ram_csn;
            cap_clk[k]   = ram_clk;
            cap_ready[k] = req_ready;
            cap_rv[k]    = rdata_valid;
            cap_bank[k]  = ram_bank;
            cap_o[k]     = ram_io_o;
            cap_oe[k]    = ram_io_oe;
            cap_rdata[k] = rdata;
            if (scramble) begin
                req_addr  = 24'($urandom);
                req_bank  = 2'($urandom);
                req_wdata = 8'($urandom);
                req_rnw   = 1'($urandom);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL reset_ready: got %b expected 1", req_ready); end
        total++; if (rdata !== 8'h00) begin bad++; $display("[TB] FAIL reset_rdata: got %h expected 00", rdata); end
        total++; if (rdata_valid !== 1'b0) begin bad++; $display("[TB] FAIL reset_rvalid: got %b expected 0", rdata_valid); end
        total++; if (ram_csn !== 1'b1) begin bad++; $display("[TB] FAIL reset_csn: got %b expected 1", ram_csn); end
        total++; if (ram_clk !== 1'b0) begin bad++; $display("[TB] FAIL reset_clk: got %b expected 0", ram_clk); end
        total++; if (ram_bank !== 2'd0) begin bad++; $display("[TB] FAIL reset_bank: got %0d expected 0", ram_bank); end
        total++; if (ram_io_o !== 4'h0) begin bad++; $display("[TB] FAIL reset_io_o: got %h expected 0", ram_io_o); end
        total++; if (ram_io_oe !== 4'h0) begin bad++; $display("[TB] FAIL reset_io_oe: got %h expected 0", ram_io_oe); end
    endtask

    task automatic test_write();
        start_req(1'b0, 24'h123456, 2'd2, 8'hA5, 1'b0);
        capture(1, 40, 1'b0);
        total++; if (cmd_byte(1) !== 8'h38) begin bad++; $display("[TB] FAIL wr_cmd: got %h expected 38", cmd_byte(1)); end
        total++; if (cap_oe[1] !== 4'b0001) begin bad++; $display("[TB] FAIL wr_cmd_oe: got %b expected 0001", cap_oe[1]); end
        total++; if (cap_clk[1] !== 1'b0 || cap_clk[2] !== 1'b1) begin bad++; $display("[TB] FAIL wr_sclk: got %b%b expected 01", cap_clk[1], cap_clk[2]); end
        total++; if (nibbles(17, 6) !== 24'h123456) begin bad++; $display("[TB] FAIL wr_addr: got %h expected 123456", nibbles(17, 6)); end
        total++; if (cap_oe[17] !== 4'b1111) begin bad++; $display("[TB] FAIL wr_addr_oe: got %b expected 1111", cap_oe[17]); end
        total++; if (nibbles(29, 2) !== 24'h0000A5) begin bad++; $display("[TB] FAIL wr_data: got %h expected A5", nibbles(29, 2)); end
        total++; if (count_csn_low(1, 40) !== 32) begin bad++; $display("[TB] FAIL wr_csn_len: got %0d expected 32", count_csn_low(1, 40)); end
        total++; if (cap_csn[32] !== 1'b0 || cap_csn[33] !== 1'b1) begin bad++; $display("[TB] FAIL wr_csn_end: got %b%b expected 01", cap_csn[32], cap_csn[33]); end
        total++; if (cap_bank[1] !== 2'd2) begin bad++; $display("[TB] FAIL wr_bank: got %0d expected 2", cap_bank[1]); end
        total++; if (cap_ready[34] !== 1'b0 || cap_ready[35] !== 1'b1) begin bad++; $display("[TB] FAIL wr_ready: got %b%b expected 01", cap_ready[34], cap_ready[35]); end
    endtask

    task automatic test_read();
        int oe_hits;
        m_rdata = 8'h3C;
        start_req(1'b1, 24'h00FFEE, 2'd1, 8'h00, 1'b0);
        capture(1, 50, 1'b0);
        oe_hits = 0;
        for (int k = 29; k <= 44; k++) if (cap_oe[k] !== 4'h0) oe_hits++;
        total++; if (oe_hits !== 0) begin bad++; $display("[TB] FAIL rd_oe_off: got %0d driven cycles expected 0", oe_hits); end
        total++; if (m_cmd !== 8'hEB) begin bad++; $display("[TB] FAIL rd_cmd: got %h expected EB", m_cmd); end
        total++; if (m_addr !== 24'h00FFEE) begin bad++; $display("[TB] FAIL rd_addr: got %h expected 00FFEE", m_addr); end
        total++; if (cap_rv[45] !== 1'b1) begin bad++; $display("[TB] FAIL rd_valid_t45: got %b expected 1", cap_rv[45]); end
        total++; if (count_rv(1, 50) !== 1) begin bad++; $display("[TB] FAIL rd_valid_count: got %0d expected 1", count_rv(1, 50)); end
        total++; if (cap_rdata[45] !== 8'h3C) begin bad++; $display("[TB] FAIL rd_data: got %h expected 3C", cap_rdata[45]); end
        total++; if (cap_rdata[50] !== 8'h3C) begin bad++; $display("[TB] FAIL rd_data_hold: got %h expected 3C", cap_rdata[50]); end
        total++; if (cap_csn[44] !== 1'b0 || cap_csn[45] !== 1'b1) begin bad++; $display("[TB] FAIL rd_csn_end: got %b%b expected 01", cap_csn[44], cap_csn[45]); end
        total++; if (cap_ready[46] !== 1'b0 || cap_ready[47] !== 1'b1) begin bad++; $display("[TB] FAIL rd_ready: got %b%b expected 01", cap_ready[46], cap_ready[47]); end
        total++; if (cap_bank[1] !== 2'd1) begin bad++; $display("[TB] FAIL rd_bank: got %0d expected 1", cap_bank[1]); end
    endtask

    task automatic test_back_to_back();
        int csn_high;
        m_rdata = 8'h96;
        start_req(1'b1, 24'h000100, 2'd3, 8'h00, 1'b1);
        req_rnw   = 1'b0;
        req_addr  = 24'h0A0B0C;
        req_bank  = 2'd2;
        req_wdata = 8'hC3;
        capture(1, 47, 1'b0);
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        capture(48, 90, 1'b0);
        // Between transfers csn stays high through both DESEL cycles and the
        // single IDLE cycle in which the second request is accepted.
        csn_high = 0;
        for (int k = 45; k <= 47; k++) if (cap_csn[k] === 1'b1) csn_high++;
        total++; if (cap_rv[45] !== 1'b1 || cap_rdata[45] !== 8'h96) begin bad++; $display("[TB] FAIL b2b_rdata: got %b/%h expected 1/96", cap_rv[45], cap_rdata[45]); end
        total++; if (cap_ready[47] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready47: got %b expected 1", cap_ready[47]); end
        total++; if (csn_high !== 3 || cap_csn[44] !== 1'b0 || cap_csn[48] !== 1'b0) begin bad++; $display("[TB] FAIL b2b_csn_gap: got %0d high (edges %b/%b) expected 3 (0/0)", csn_high, cap_csn[44], cap_csn[48]); end
        total++; if (cap_bank[47] !== 2'd3 || cap_bank[48] !== 2'd2) begin bad++; $display("[TB] FAIL b2b_bank: got %0d->%0d expected 3->2", cap_bank[47], cap_bank[48]); end
        total++; if (cmd_byte(48) !== 8'h38) begin bad++; $display("[TB] FAIL b2b_cmd: got %h expected 38", cmd_byte(48)); end
        total++; if (nibbles(64, 6) !== 24'h0A0B0C) begin bad++; $display("[TB] FAIL b2b_addr: got %h expected 0A0B0C", nibbles(64, 6)); end
        total++; if (nibbles(76, 2) !== 24'h0000C3) begin bad++; $display("[TB] FAIL b2b_wdata: got %h expected C3", nibbles(76, 2)); end
        total++; if (cap_ready[81] !== 1'b0 || cap_ready[82] !== 1'b1) begin bad++; $display("[TB] FAIL b2b_ready2: got %b%b expected 01", cap_ready[81], cap_ready[82]); end
    endtask

    task automatic test_reset_mid_read();
        int rv_seen;
        m_rdata = 8'h5A;
        start_req(1'b1, 24'h000ABC, 2'd1, 8'h00, 1'b0);
        capture(1, 20, 1'b0);
        total++; if (cap_csn[20] !== 1'b0 || cap_oe[20] !== 4'b1111) begin bad++; $display("[TB] FAIL mid_pre: got csn=%b oe=%b expected 0/1111", cap_csn[20], cap_oe[20]); end
        rst_n = 1'b0;
        #1;
        total++; if (ram_csn !== 1'b1) begin bad++; $display("[TB] FAIL mid_csn: got %b expected 1", ram_csn); end
        total++; if (ram_clk !== 1'b0) begin bad++; $display("[TB] FAIL mid_clk: got %b expected 0", ram_clk); end
        total++; if (ram_io_oe !== 4'h0) begin bad++; $display("[TB] FAIL mid_oe: got %b expected 0000", ram_io_oe); end
        total++; if (req_ready !== 1'b1) begin bad++; $display("[TB] FAIL mid_ready: got %b expected 1", req_ready); end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        rv_seen = 0;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (rdata_valid !== 1'b0) rv_seen++;
        end
        total++; if (rv_seen !== 0) begin bad++; $display("[TB] FAIL mid_no_valid: got %0d pulses expected 0", rv_seen); end
        total++; if (rdata !== 8'h00) begin bad++; $display("[TB] FAIL mid_rdata: got %h expected 00", rdata); end
        start_req(1'b0, 24'h654321, 2'd1, 8'h7E, 1'b0);
        capture(1, 40, 1'b0);
        total++; if (nibbles(17, 6) !== 24'h654321) begin bad++; $display("[TB] FAIL mid_wr_addr: got %h expected 654321", nibbles(17, 6)); end
        total++; if (nibbles(29, 2) !== 24'h00007E) begin bad++; $display("[TB] FAIL mid_wr_data: got %h expected 7E", nibbles(29, 2)); end
        total++; if (count_csn_low(1, 40) !== 32) begin bad++; $display("[TB] FAIL mid_wr_csn: got %0d expected 32", count_csn_low(1, 40)); end
        total++; if (cap_ready[35] !== 1'b1) begin bad++; $display("[TB] FAIL mid_wr_ready: got %b expected 1", cap_ready[35]); end
    endtask

    task automatic test_input_stability();
        start_req(1'b0, 24'hABCDEF, 2'd1, 8'h5A, 1'b0);
        capture(1, 34, 1'b1);
        req_rnw   = 1'b0;
        req_addr  = '0;
        req_bank  = '0;
        req_wdata = '0;
        total++; if (cmd_byte(1) !== 8'h38) begin bad++; $display("[TB] FAIL stab_cmd: got %h expected 38", cmd_byte(1)); end
        total++; if (nibbles(17, 6) !== 24'hABCDEF) begin bad++; $display("[TB] FAIL stab_addr: got %h expected ABCDEF", nibbles(17, 6)); end
        total++; if (nibbles(29, 2) !== 24'h00005A) begin bad++; $display("[TB] FAIL stab_data: got %h expected 5A", nibbles(29, 2)); end
        total++; if (cap_bank[1] !== 2'd1 || cap_bank[30] !== 2'd1) begin bad++; $display("[TB] FAIL stab_bank: got %0d/%0d expected 1/1", cap_bank[1], cap_bank[30]); end
        total++; if (count_csn_low(1, 34) !== 32) begin bad++; $display("[TB] FAIL stab_csn: got %0d expected 32", count_csn_low(1, 34)); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_back_to_back();
        test_reset_mid_read();
        test_input_stability();
        repeat (5) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
